ds3502_arbiter: RTL and testbench
=================================

# ds3502_arbiter

Round-robin arbiter and sequencer that shares one `ds3502` digital-potentiometer I2C driver among N requesters. Each requester posts an 8-bit wiper value. The block coalesces repeated posts, drops writes of the value already on the wiper, and issues one `load` pulse per transaction. It then tracks the driver's `busy` handshake with start and completion timeouts. It sits between the control logic (calibration, host register file) and the `ds3502` instance.

## Interface
- `N`, 4, number of requesters, legal range 2..8.
- `START_TO`, 8, cycles to wait for `drv_busy` to rise after `drv_load`.
- `DONE_TO`, 65535, cycles to wait for `drv_busy` to fall once it has risen.

- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N: bit i high for one cycle posts `req_r[8*i+:8]`.
- `req_r` in 8*N: posted wiper values.
- `req_pend` out N: requester i has a value queued, not yet granted.
- `req_done` out N: one-cycle pulse when requester i's value has been written, or skipped as redundant.
- `grant_id` out 3: index of the requester currently or last granted.
- `cur_r` out 8: last value confirmed written.
- `cur_valid` out 1: `cur_r` reflects the device.
- `drv_load` out 1: one-cycle strobe to driver `load`.
- `drv_r` out 8: value to driver `r`, stable from `drv_load` until return to IDLE.
- `drv_busy` in 1: driver `busy`.
- `err_timeout` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err_timeout`.

## Operation
- **Posting.** `req_valid[i]` captures `req_r[i]` into `pend_val[i]` and sets `pend[i]`. A new post before grant overwrites the old one, so only the last value is written and only one `req_done` is produced.
- **States.** IDLE, ISSUE, WAIT_START, WAIT_DONE.
- **IDLE.** If any `pend` is set and `drv_busy`=0, grant the first pending index in order ptr+1 … ptr+N (mod N).
  - On grant: set ptr=grant, `grant_id`=grant, `drv_r`=`pend_val[grant]`, and clear `pend[grant]`.
  - If `req_valid[grant]` is high in the grant cycle, `pend[grant]` stays set with the new value.
  - Redundant grant: if `cur_valid`=1 and the value equals `cur_r`, pulse `req_done[grant]` next cycle and stay in IDLE. No `drv_load` is issued.
  - Otherwise go to ISSUE.
- **ISSUE.** `drv_load`=1 for this cycle only. Clear `cnt`, go to WAIT_START.
- **WAIT_START.**
  - `drv_busy`=1: clear `cnt`, go to WAIT_DONE.
  - Else increment `cnt`. When `cnt`=START_TO-1: set `err_timeout`=1, clear `cur_valid`, go to IDLE with no `req_done`.
- **WAIT_DONE.**
  - `drv_busy`=0: set `cur_r`=`drv_r`, `cur_valid`=1, pulse `req_done[grant_id]`, go to IDLE.
  - Else increment `cnt`. When `cnt`=DONE_TO-1: set `err_timeout`=1, clear `cur_valid`, go to IDLE.
  - A timed-out value is dropped, not re-queued.
- **Counter.** `cnt` is 16 bits and saturates; it never wraps.
- **Error flag.** `err_clr` clears `err_timeout`. A timeout in the same cycle as `err_clr` wins, so the flag ends set.

## Timing
- **Reset values.**
  - All outputs 0.
  - ptr=N-1, so requester 0 wins the first tie.
  - `pend`=0, state IDLE, `cnt`=0.
- **Reset mid-transaction.** The block returns to IDLE at once and does not abort the driver. Because grants require `drv_busy`=0, no new `drv_load` is issued until the in-flight transaction ends.
- **Post-to-load latency.** `req_valid` high in cycle c, with the block idle and the driver not busy, gives `drv_load` high in cycle c+2.
- **Done latency.** `req_done` is high in the cycle after `drv_busy` is sampled low in WAIT_DONE.
- **Back-to-back requesters.** The next grant occurs in the first IDLE cycle, so `drv_load` pulses are at least 3 cycles plus the busy window apart.
- **Redundant write.** `req_done` is high in cycle c+2 after the post, with no `drv_load`.
- **Registered outputs.** All outputs are registered and there are no combinational paths from inputs to outputs.
- **Busy-rise window.** `drv_busy` rising in the same cycle as `drv_load` is legal; it is seen in WAIT_START the next cycle.

## Test plan
- **Single write.** Reset; post 0x05 on req 0. Expect `drv_load` at c+2 with `drv_r`=0x05. Model busy rising 1 cycle later for 100 cycles. Expect `req_done[0]` one cycle after busy falls, then `cur_r`=0x05 and `cur_valid`=1.
- **Round-robin.** Post req 0, 1 and 3 in the same cycle. Expect grants in order 0, 1, 3, with three `drv_load` pulses and `req_done` in the same order. Repost 0 and 3 after grant 3; expect order 0, 3.
- **Coalescing.** Hold the driver busy externally; post 0x10 then 0x20 on req 2. Release busy. Expect a single write of 0x20 and one `req_done[2]`.
- **Redundant write.** After `cur_r`=0x20, post 0x20 on req 1. Expect `req_done[1]` at c+2 and no `drv_load`.
- **Start timeout.** Never raise `drv_busy`. Expect `err_timeout`=1 START_TO cycles after ISSUE, `cur_valid`=0, no `req_done`. Pulse `err_clr`; expect the flag cleared.
- **Reset mid-transaction.** Assert `rst` during WAIT_DONE with `drv_busy` high. Expect all outputs 0, and no `drv_load` until `drv_busy` drops, even with pending posts.

Source files
------------

// File: rtl/ds3502_arbiter.sv
// ds3502_arbiter: round-robin sharing of one ds3502 driver among N requesters,
// with post coalescing, redundant-write skipping and busy handshake timeouts.
module ds3502_arbiter #(
  parameter int N        = 4,
  parameter int START_TO = 8,
  parameter int DONE_TO  = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_r,
  output logic [N-1:0]     req_pend,
  output logic [N-1:0]     req_done,
  output logic [2:0]       grant_id,
  output logic [7:0]       cur_r,
  output logic             cur_valid,
  output logic             drv_load,
  output logic [7:0]       drv_r,
  input  logic             drv_busy,
  output logic             err_timeout,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  localparam logic [15:0] START_LIM = 16'(START_TO - 1);
  localparam logic [15:0] DONE_LIM  = 16'(DONE_TO - 1);
  localparam logic [2:0]  PTR_RST   = 3'(N - 1);

  state_t       state;
  state_t       state_nx;
  logic [2:0]   ptr;
  logic [15:0]  cnt;
  logic [N-1:0] pend;
  logic [7:0]   pend_val [N];

  logic         gnt_hit;
  logic [2:0]   gnt_idx;
  logic [7:0]   gnt_val;
  logic [N-1:0] gnt_oh;
  logic [N-1:0] gid_oh;
  logic         gnt_fire;
  logic         gnt_red;
  logic         xfer_ok;
  logic         tmo;

  assign req_pend = pend;

  // Lowest rotation distance from ptr wins; k=1 is visited last.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      for (int j = 0; j < N; j++) begin
        if (j == (int'(ptr) + k) % N && pend[j]) begin
          gnt_hit = 1'b1;
          gnt_idx = 3'(j);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt_fire && !gnt_red) state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx = WAIT_START;
      end
      WAIT_START: begin
        if (drv_busy)                state_nx = WAIT_DONE;
        else if (cnt == START_LIM)   state_nx = IDLE;
      end
      WAIT_DONE: begin
        if (!drv_busy || cnt == DONE_LIM) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_val = '0;
    gnt_oh  = '0;
    gid_oh  = '0;
    for (int j = 0; j < N; j++) begin
      if (gnt_idx == 3'(j)) begin
        gnt_val   = pend_val[j];
        gnt_oh[j] = 1'b1;
      end
      if (grant_id == 3'(j)) gid_oh[j] = 1'b1;
    end
    gnt_fire = (state == IDLE) && gnt_hit && !drv_busy;
    gnt_red  = cur_valid && (gnt_val == cur_r);
    xfer_ok  = (state == WAIT_DONE) && !drv_busy;
    tmo      = ((state == WAIT_START) && !drv_busy
                && (cnt == START_LIM))
             || ((state == WAIT_DONE) && drv_busy
                && (cnt == DONE_LIM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= PTR_RST;
      grant_id    <= '0;
      drv_r       <= '0;
      drv_load    <= 1'b0;
      req_done    <= '0;
      cur_r       <= '0;
      cur_valid   <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
      pend        <= '0;
      for (int j = 0; j < N; j++) pend_val[j] <= '0;
    end else begin
      drv_load <= gnt_fire && !gnt_red;
      req_done <= '0;
      if (gnt_fire) begin
        ptr      <= gnt_idx;
        grant_id <= gnt_idx;
        drv_r    <= gnt_val;
        if (gnt_red) req_done <= gnt_oh;
      end
      if (xfer_ok) begin
        cur_r     <= drv_r;
        cur_valid <= 1'b1;
        req_done  <= gid_oh;
      end
      if (tmo) cur_valid <= 1'b0;
      if (tmo)          err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (state == IDLE || state == ISSUE
          || (state == WAIT_START && drv_busy))
        cnt <= '0;
      else if (cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
      // A post in the grant cycle re-arms the slot with the new value.
      for (int j = 0; j < N; j++) begin
        if (gnt_fire && gnt_idx == 3'(j)) pend[j] <= 1'b0;
        if (req_valid[j]) begin
          pend[j]     <= 1'b1;
          pend_val[j] <= req_r[8*j +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ds3502_arbiter.sv
// Bench for ds3502_arbiter: a transaction-level model fills expected queues,
// a monitor pops them on every drv_load and req_done.
`timescale 1ns/1ps
module tb_ds3502_arbiter;
  localparam int N        = 4;
  localparam int START_TO = 8;
  localparam int DONE_TO  = 65535;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_r;
  logic [N-1:0]   req_pend;
  logic [N-1:0]   req_done;
  logic [2:0]     grant_id;
  logic [7:0]     cur_r;
  logic           cur_valid;
  logic           drv_load;
  logic [7:0]     drv_r;
  logic           drv_busy;
  logic           err_timeout;
  logic           err_clr;

  logic ext_hold;
  logic resp_busy;
  bit   resp_en;
  int   resp_delay;
  int   resp_len;

  assign drv_busy = ext_hold | resp_busy;

  ds3502_arbiter #(
    .N(N), .START_TO(START_TO), .DONE_TO(DONE_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_r(req_r),
    .req_pend(req_pend), .req_done(req_done),
    .grant_id(grant_id), .cur_r(cur_r),
    .cur_valid(cur_valid), .drv_load(drv_load),
    .drv_r(drv_r), .drv_busy(drv_busy),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int val;
  } exp_t;

  exp_t load_q[$];
  exp_t done_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Model: last posted value per requester, pointer, device value
  int mptr;
  int mcur;
  int mv [N];
  bit mp [N];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    mptr = N - 1;
    mcur = -1;
    for (int i = 0; i < N; i++) begin
      mp[i] = 1'b0;
      mv[i] = 0;
    end
  endtask

  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (mp[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic post(input logic [N-1:0] m,
                      input logic [8*N-1:0] vals);
    req_valid = m;
    req_r     = vals;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        mp[i] = 1'b1;
        mv[i] = int'(vals[8*i +: 8]);
      end
    end
    tick(1);
    req_valid = '0;
  endtask

  // Resolve every pending post in round-robin order; lost = no completion.
  task automatic model_issue(input bit lost);
    int g;
    exp_t e;
    while (model_mask() != 0) begin
      g = -1;
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && mp[(mptr + k) % N]) g = (mptr + k) % N;
      end
      mptr  = g;
      mp[g] = 1'b0;
      e.id  = g;
      e.val = mv[g];
      if (mcur == mv[g]) begin
        done_q.push_back(e);
      end else begin
        load_q.push_back(e);
        if (lost) begin
          mcur = -1;
        end else begin
          done_q.push_back(e);
          mcur = mv[g];
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((load_q.size() + done_q.size()) != 0 && t < 5000) begin
      tick(1);
      t++;
    end
    check(name, load_q.size() + done_q.size(), 0);
    load_q.delete();
    done_q.delete();
    tick(2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pend"}, int'(req_pend), 0);
    check({tag, "_done"}, int'(req_done), 0);
    check({tag, "_gid"}, int'(grant_id), 0);
    check({tag, "_cur_r"}, int'(cur_r), 0);
    check({tag, "_cur_valid"}, int'(cur_valid), 0);
    check({tag, "_load"}, int'(drv_load), 0);
    check({tag, "_drv_r"}, int'(drv_r), 0);
    check({tag, "_err"}, int'(err_timeout), 0);
  endtask

  // Driver model: busy rises resp_delay cycles after load, lasts resp_len
  initial begin
    resp_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (drv_load && resp_en && !rst) begin
        repeat (resp_delay) @(negedge clk);
        resp_busy = 1'b1;
        repeat (resp_len) @(negedge clk);
        resp_busy = 1'b0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (drv_load) begin
          if (load_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_load: got drv_r=%0h expected none",
                     drv_r);
          end else begin
            e = load_q.pop_front();
            check("load_id", int'(grant_id), e.id);
            check("load_val", int'(drv_r), e.val);
          end
        end
        if (req_done != '0) begin
          if (done_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got %0h expected none",
                     req_done);
          end else begin
            e = done_q.pop_front();
            check("done_id", int'(req_done), 1 << e.id);
            check("done_cur_r", int'(cur_r), e.val);
            check("done_cur_valid", int'(cur_valid), 1);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [N-1:0]   m;
  logic [8*N-1:0] vals;
  int             t;
  int             ld_cyc;
  int             er_cyc;
  bit             bad;

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_r      = '0;
    err_clr    = 1'b0;
    ext_hold   = 1'b0;
    resp_en    = 1'b1;
    resp_delay = 1;
    resp_len   = 100;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    // Single write with load latency
    post(4'b0001, 32'h0000_0005);
    model_issue(1'b0);
    check("lat_c1_load", int'(drv_load), 0);
    tick(1);
    check("lat_c2_load", int'(drv_load), 1);
    check("lat_c2_drv_r", int'(drv_r), 8'h05);
    wait_drain("single_drain");
    check("single_cur_r", int'(cur_r), 8'h05);
    check("single_cur_valid", int'(cur_valid), 1);

    // Round robin from a fresh pointer
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    resp_len = 6;
    post(4'b1011, 32'h1300_1211);
    model_issue(1'b0);
    wait_drain("rr_drain1");
    post(4'b1001, 32'h2300_0021);
    model_issue(1'b0);
    wait_drain("rr_drain2");

    // Coalescing behind an externally busy driver
    ext_hold = 1'b1;
    post(4'b0100, 32'h0010_0000);
    post(4'b0100, 32'h0020_0000);
    check("coal_pend", int'(req_pend), 4'b0100);
    model_issue(1'b0);
    ext_hold = 1'b0;
    wait_drain("coal_drain");
    check("coal_cur_r", int'(cur_r), 8'h20);

    // Redundant write
    post(4'b0010, 32'h0000_2000);
    model_issue(1'b0);
    check("red_c1_done", int'(req_done), 0);
    tick(1);
    check("red_c2_done", int'(req_done), 4'b0010);
    check("red_c2_load", int'(drv_load), 0);
    wait_drain("red_drain");

    // Randomized rounds
    for (int r = 0; r < 30; r++) begin
      resp_delay = $urandom_range(0, 3);
      resp_len   = $urandom_range(1, 12);
      ext_hold   = 1'b1;
      for (int p = 0; p < int'($urandom_range(1, 5)); p++) begin
        m = N'($urandom_range(1, (1 << N) - 1));
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 3) == 0)
            vals[8*i +: 8] = 8'(mcur);
          else
            vals[8*i +: 8] = 8'($urandom_range(8'h40, 8'h43));
        end
        post(m, vals);
      end
      check("rand_pend", int'(req_pend), model_mask());
      model_issue(1'b0);
      ext_hold = 1'b0;
      wait_drain("rand_drain");
    end

    // Start timeout: driver never responds
    resp_en = 1'b0;
    post(4'b0001, 32'h0000_0033);
    model_issue(1'b1);
    t = 0;
    while (!drv_load && t < 20) begin
      tick(1);
      t++;
    end
    check("to_load_seen", int'(drv_load), 1);
    ld_cyc = cyc;
    t = 0;
    while (!err_timeout && t < 40) begin
      tick(1);
      t++;
    end
    er_cyc = cyc;
    check("to_err_set", int'(err_timeout), 1);
    check("to_latency_ok",
          int'(er_cyc - ld_cyc >= START_TO
               && er_cyc - ld_cyc <= START_TO + 1), 1);
    check("to_cur_valid", int'(cur_valid), 0);
    tick(3);
    check("to_err_sticky", int'(err_timeout), 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("to_err_cleared", int'(err_timeout), 0);
    wait_drain("to_drain");

    // Reset in the middle of WAIT_DONE
    resp_en    = 1'b1;
    resp_delay = 1;
    resp_len   = 60;
    post(4'b1000, 32'h4400_0000);
    model_issue(1'b1);
    t = 0;
    while (!drv_busy && t < 20) begin
      tick(1);
      t++;
    end
    check("mid_busy_seen", int'(drv_busy), 1);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    check_zero("mid_reset");
    post(4'b0010, 32'h0000_5500);
    model_issue(1'b0);
    check("mid_pend", int'(req_pend), 4'b0010);
    bad = 1'b0;
    t = 0;
    while (drv_busy && t < 300) begin
      if (drv_load) bad = 1'b1;
      tick(1);
      t++;
    end
    check("mid_no_load_busy", int'(bad), 0);
    check("mid_busy_fell", int'(drv_busy), 0);
    wait_drain("mid_drain");
    check("mid_cur_r", int'(cur_r), 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
